// File: rtl/ripple_add_sequencer_if.sv
// Request/result handshake bundle for the sliced add/subtract sequencer.
// The requester takes the master modport and the sequencer takes the slave modport.
interface ripple_add_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/ripple_add_sequencer.sv
// WIDTH-bit add/subtract computed one nibble per cycle through a
// single shared 4-bit ripple-carry adder, least-significant slice first.
module ripple_carry_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[4];
endmodule

module ripple_add_sequencer #(
  parameter int WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst,
  ripple_add_sequencer_if.slave bus
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IW     = $clog2(NSLICE);
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic             cy;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             out_valid_r;
  logic             busy_r;

  logic [3:0] sl_a;
  logic [3:0] sl_b;
  logic [3:0] sl_s;
  logic       sl_co;

  assign sl_a = a_reg[idx*4 +: 4];
  assign sl_b = b_reg[idx*4 +: 4];

  ripple_carry_adder u_rca (
    .a  (sl_a),
    .b  (sl_b),
    .ci (cy),
    .s  (sl_s),
    .co (sl_co)
  );

  // b_reg holds the effective operand: inverted for subtract
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      cy          <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg  <= bus.a;
            b_reg  <= bus.sub ? ~bus.b : bus.b;
            cy     <= bus.sub | bus.cin;
            idx    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          sum_r[idx*4 +: 4] <= sl_s;
          cy                <= sl_co;
          if (idx == LAST) begin
            cout_r      <= sl_co;
            ovf_r       <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                           (sl_s[3] != a_reg[WIDTH-1]);
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = !rst && (state == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_ripple_add_sequencer.sv
// Bench for ripple_add_sequencer: directed vector table, backpressure,
// mid-run reset and randomized operations against an arithmetic model.
module tb_ripple_add_sequencer;
  localparam int W      = 16;
  localparam int NSLICE = W / 4;

  logic clk;
  logic rst;

  ripple_add_sequencer_if #(.WIDTH(W)) bus ();

  ripple_add_sequencer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] esum;
    logic         ecout;
    logic         eovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected result from plain integer arithmetic on the operands
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub,
                       output logic [W-1:0] s, output logic co,
                       output logic ov);
    longint ua, ub, full, sa, sb, res;
    ua = longint'(a);
    ub = longint'(b);
    sa = (a[W-1]) ? ua - (64'sd1 <<< W) : ua;
    sb = (b[W-1]) ? ub - (64'sd1 <<< W) : ub;
    if (sub) begin
      full = ua - ub;
      co   = (ua >= ub);
      res  = sa - sb;
    end else begin
      full = ua + ub + longint'(cin);
      co   = (full >= (64'sd1 <<< W));
      res  = sa + sb + longint'(cin);
    end
    s  = full[W-1:0];
    ov = (res > ((64'sd1 <<< (W-1)) - 1)) || (res < -(64'sd1 <<< (W-1)));
  endtask

  // Present a request at a falling edge; it is taken on the next rising edge
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    chk("in_ready_before_issue", 32'(bus.in_ready), 32'd1);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.cin      = 1'($urandom);
    bus.sub      = 1'($urandom);
  endtask

  task automatic collect(input string name, input logic [W-1:0] es,
                         input logic ec, input logic eo, input bit ack);
    int cnt;
    cnt = 1;
    while (!bus.out_valid && cnt < 40) begin
      chk({name, "_busy"}, 32'(bus.busy), 32'd1);
      @(negedge clk);
      cnt++;
    end
    chk({name, "_latency"}, 32'(cnt), 32'(NSLICE + 1));
    chk({name, "_sum"}, 32'(bus.sum), 32'(es));
    chk({name, "_cout"}, 32'(bus.cout), 32'(ec));
    chk({name, "_ovf"}, 32'(bus.ovf), 32'(eo));
    if (ack) begin
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk({name, "_drop_valid"}, 32'(bus.out_valid), 32'd0);
      chk({name, "_hold_sum"}, 32'(bus.sum), 32'(es));
    end
  endtask

  initial begin
    logic [W-1:0] ms;
    logic         mc;
    logic         mo;

    vecs.push_back('{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
    vecs.push_back('{16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1});
    vecs.push_back('{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0});
    vecs.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0});
    vecs.push_back('{16'h0000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1});

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout_ovf", {30'd0, bus.cout, bus.ovf}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      collect($sformatf("vec%0d", i), vecs[i].esum, vecs[i].ecout,
              vecs[i].eovf, 1'b1);
    end

    // Backpressure with a competing request held during DONE
    issue(16'h1111, 16'h2222, 1'b0, 1'b0);
    collect("bp", 16'h3333, 1'b0, 1'b0, 1'b0);
    bus.a        = 16'h0003;
    bus.b        = 16'h0004;
    bus.cin      = 1'b0;
    bus.sub      = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_sum", 32'(bus.sum), 32'h3333);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_idle_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_idle_busy", 32'(bus.busy), 32'd0);
    chk("bp_idle_sum", 32'(bus.sum), 32'h3333);
    issue(16'h0003, 16'h0004, 1'b0, 1'b0);
    collect("bp_next", 16'h0007, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset while slice 2 is in progress
    issue(16'h8888, 16'h8888, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_sum", 32'(bus.sum), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_rst_no_valid", 32'(bus.out_valid), 32'd0);
    end
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
    collect("after_rst", 16'h0100, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic         rc, rs;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      model(ra, rb, rc, rs, ms, mc, mo);
      issue(ra, rb, rc, rs);
      collect($sformatf("rnd%0d", i), ms, mc, mo, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ripple_add_sequencer.md
Name: ripple_add_sequencer

Overview:
Multi-cycle controller that computes WIDTH-bit add/subtract using a single shared 4-bit ripple_carry_adder instance.
- Each cycle it feeds one 4-bit operand slice plus a registered carry into the adder, least-significant slice first.
- It collects the sum slices and presents the full result on a valid/ready output handshake.
- It is the standard wide-arithmetic front end for the 4-bit datapath, trading latency for area.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 8.
NSLICE, WIDTH/4, number of 4-bit slices (derived; not overridable).

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  request carries a valid operation
in_ready  output  1  block can accept a request this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in for add; ignored when sub=1
sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  carry out of MSB (for sub: 1 = no borrow)
ovf  output  1  signed two's-complement overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: state=IDLE, slice index=0, carry reg=0, sum=0, cout=0, ovf=0, out_valid=0, busy=0. in_ready=1 once reset deasserts.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at edge E0, capture a, and b_eff = sub ? ~b : b.
  - Capture carry reg = sub ? 1 : cin.
  - Set index=0 and go to RUN.
- RUN:
  - in_ready=0.
  - Combinationally drive the adder with a_reg[4k+3:4k], b_eff[4k+3:4k] and carry reg, where k = index.
  - Each edge: sum[4k+3:4k] <= adder S; carry reg <= adder Cout; index <= index+1.
  - The edge that processes k=NSLICE-1 also does the following, then goes to DONE:
    - cout <= adder Cout.
    - ovf <= (a_reg[MSB] == b_eff[MSB]) && (new sum[MSB] != a_reg[MSB]).
- Latency: slice k is processed on edge E(k+1). out_valid rises immediately after edge E(NSLICE), i.e. NSLICE cycles after the accept edge (4 for default).
- DONE:
  - out_valid=1 and in_ready=0.
  - sum, cout, ovf are stable while out_valid=1 && !out_ready.
  - On out_valid & out_ready, go to IDLE and drop out_valid.
  - No same-cycle bypass: a request presented during the accepting DONE cycle is taken on the following IDLE cycle.
- sum during RUN is partial and must not be consumed. After the handshake, sum/cout/ovf hold their last value until the next accept overwrites them.
- Width rules: all arithmetic modulo 2^WIDTH. cout is the true carry out of bit WIDTH-1. The index counter is ceil(log2(NSLICE)) bits and never wraps past NSLICE-1.
- Operand capture: a, b, cin, sub are sampled only at the accept edge; later input changes have no effect.
- in_valid while busy: ignored; the requester holds it until in_ready.
- Reset in any state: immediately return to IDLE, clear all outputs, discard any in-flight operation, and assert no out_valid.
- busy = (state != IDLE).

Test Plan:
- Basic add, cross-slice ripple: a=0x00FF, b=0x0001, cin=0, sub=0 -> after 4 cycles out_valid=1, sum=0x0100, cout=0, ovf=0.
- Full carry out and cin: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0. Then a=0x1234, b=0x0FCD, cin=0 -> sum=0x2201, cout=0.
- Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. Also a=0x8000, b=0xFFFF -> sum=0x7FFF, cout=1, ovf=1.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0. Then a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands.
  - Required: outputs stable, in_ready=0, new request not accepted.
  - Raise out_ready: handshake, IDLE next cycle, new request accepted, its result correct.
- Reset mid-RUN: assert rst asynchronously during slice 2 -> outputs zero immediately, state IDLE, no out_valid afterwards. A subsequent 0x00FF+0x0001 yields 0x0100 with normal 4-cycle latency.
